bus_slave_ram: RTL and testbench
================================

Name: bus_slave_ram

Overview:
Bus responder that terminates one master port of the core's bus, either the instruction port or the data port. It is backed by a word-addressed on-chip RAM with byte-masked writes and a configurable number of wait states. It answers with data/valid/stall/err signalling, so the core's bus masters can be exercised with both single-cycle and multi-cycle memories. One instance sits behind each master port in the SoC and in the core testbench.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two, at least 2.
BASE_ADDR, 30'h0, word address of RAM word 0; must be DEPTH_WORDS-aligned.
WAIT_STATES, 0, extra stall cycles per access (0..15).
INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
req_i  in  1  master request valid
we_i  in  1  1 = write, 0 = read
addr_i  in  30  word address
data_i  in  32  write data
mask_i  in  4  byte enables; bit n covers data[8n+7:8n]
data_o  out  32  read data
valid_o  out  1  access completed OK (one-cycle pulse)
stall_o  out  1  responder busy; master must hold request stable
err_o  out  1  access failed (one-cycle pulse)

Behaviour:
- Clocking and reset: clk only. rst_b is asynchronous and active-low.
- Reset values: data_o=0, valid_o=0, err_o=0, stall_o=0, state=IDLE, wait_cnt=0.
- RAM contents are not cleared by reset.
- Accept condition: req_i & ~stall_o at a rising edge. On accept, latch we, addr, data and mask.
- In range: (addr_i - BASE_ADDR) < DEPTH_WORDS, unsigned 30-bit compare.
- RAM index: low log2(DEPTH_WORDS) bits of (addr_i - BASE_ADDR).
- FSM states: IDLE and BUSY. stall_o = (state==BUSY), decoded from the registered state.
- WAIT_STATES=0:
  - The op executes on the accept edge.
  - valid_o or err_o pulses in the next cycle, giving latency 1.
  - A new request can be accepted every cycle, fully pipelined.
- WAIT_STATES=W>0:
  - The accept edge moves IDLE->BUSY and sets wait_cnt=W.
  - In BUSY, wait_cnt decrements each edge.
  - On the edge where wait_cnt==1, the op executes and the state returns to IDLE.
  - Result: stall_o is high for exactly W cycles after the accept cycle.
  - valid_o/err_o pulses in cycle accept+W+1 with stall_o low. A new request can be accepted in that same cycle.
- While BUSY, req_i, addr_i, we_i, data_i and mask_i are ignored; the latched values are used.
- Read:
  - In range: data_o <= RAM[index] at the execute edge, then valid_o pulses.
  - Out of range: err_o pulses, valid_o stays 0, data_o <= 0.
- Write:
  - In range: RAM bytes with mask bit set are updated at the execute edge, then valid_o pulses. data_o holds its previous value.
  - mask=0 is a legal no-op and is acknowledged with valid_o.
  - Out of range: no RAM change, err_o pulses.
- valid_o and err_o are never high together, and each is high for exactly one cycle per accepted request.
- Ordering: a read accepted after a write to the same address returns the new data, with no hazard window at any WAIT_STATES.
- Reset mid-access: any pending BUSY op is aborted and its write is not committed. No valid_o/err_o pulse follows.
- Idle (no accept): valid_o=0, err_o=0, data_o holds.
- Simultaneous case: when a result pulse and a new accept share a cycle, both occur. The next result follows per latency.

Test Plan:
1. W=0. Write addr 5, data 0xDEADBEEF, mask 4'hF. Next cycle read addr 5. Required: valid pulses in cycles 1 and 2; data_o=0xDEADBEEF in cycle 2; stall_o never high.
2. W=0. Starting from word 0xDEADBEEF, write mask 4'b0100 with data 0x00AA0000. Read back. Required: 0xDEADBEEF -> 0xDEAABEEF.
3. W=3. Read request held stable. Required: stall_o high for cycles 1-3; valid_o in cycle 4 with correct data. A second request held from cycle 1 is accepted in cycle 4, and its valid arrives in cycle 8.
4. DEPTH=1024, BASE=0x100. Read addr 0x0FF, then write addr 0x500. Required: err_o pulse for each, valid_o=0, RAM unchanged on a full-RAM scan. Addr 0x4FF reads OK.
5. W=4. Write accepted, then rst_b low during cycle 2. Required: all outputs 0 asynchronously and no later valid_o. A readback after reset shows the old data.
6. W=0. 100 back-to-back random writes followed by reads of the same addresses, with mask=0 mixed in. Required: one valid per request, in order, data matches a reference model, and mask=0 writes leave words unchanged.

Source files
------------

// File: rtl/bus_slave_ram.sv
// Bus responder backed by a word-addressed on-chip RAM with byte-masked
// writes and a configurable number of wait states per access.
module bus_slave_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  mask_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } req_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nx;
    req_t             cur_req;
    req_t             lat_req;
    req_t             op;
    logic             accept;
    logic             exec;
    logic [29:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [DEPTH_WORDS];

    assign stall_o = (state == BUSY);
    assign accept  = req_i & ~stall_o;
    assign cur_req = {we_i, addr_i, data_i, mask_i};

    // Zero-wait instances execute straight from the bus; otherwise from the latch
    assign op       = (WAIT_STATES == 0) ? cur_req : lat_req;
    assign offset   = op.addr - BASE_ADDR;
    assign in_range = offset < 30'(DEPTH_WORDS);
    assign idx      = offset[IDX_W-1:0];

    // State register, wait counter and request latch
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lat_req  <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (accept) lat_req <= cur_req;
        end
    end

    // Next-state logic and execute strobe
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        exec        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        exec = 1'b1;
                    end else begin
                        state_nx    = BUSY;
                        wait_cnt_nx = WAIT_INIT;
                    end
                end
            end
            BUSY: begin
                wait_cnt_nx = wait_cnt - CNT_W'(1);
                if (wait_cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                    exec     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Response registers: one valid or err pulse per executed op
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= exec & in_range;
            err_o   <= exec & ~in_range;
            if (exec && !op.we) data_o <= in_range ? mem[idx] : '0;
        end
    end

    // Byte-masked RAM write on the execute edge
    always_ff @(posedge clk) begin
        if (exec && op.we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (op.mask[b]) mem[idx][8*b +: 8] <= op.data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_bus_slave_ram.sv
// Directed testbench for bus_slave_ram: four instances cover zero-wait,
// 3-wait, 4-wait and offset-base configurations sharing one request bus.
module tb_bus_slave_ram;

    localparam int unsigned DEPTH = 1024;

    logic        clk   = 1'b0;
    logic        rst_b = 1'b1;
    logic [3:0]  req;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    wire  [31:0] rdata [4];
    wire  [3:0]  valid;
    wire  [3:0]  stall;
    wire  [3:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_slave_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(30'h0), .WAIT_STATES(0), .INIT_FILE("")) u_w0 (
        .clk(clk), .rst_b(rst_b), .req_i(req[0]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .mask_i(mask), .data_o(rdata[0]), .valid_o(valid[0]), .stall_o(stall[0]), .err_o(err[0]));
    bus_slave_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(30'h0), .WAIT_STATES(3), .INIT_FILE("")) u_w3 (
        .clk(clk), .rst_b(rst_b), .req_i(req[1]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .mask_i(mask), .data_o(rdata[1]), .valid_o(valid[1]), .stall_o(stall[1]), .err_o(err[1]));
    bus_slave_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(30'h0), .WAIT_STATES(4), .INIT_FILE("")) u_w4 (
        .clk(clk), .rst_b(rst_b), .req_i(req[2]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .mask_i(mask), .data_o(rdata[2]), .valid_o(valid[2]), .stall_o(stall[2]), .err_o(err[2]));
    bus_slave_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(30'h100), .WAIT_STATES(0), .INIT_FILE("")) u_base (
        .clk(clk), .rst_b(rst_b), .req_i(req[3]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .mask_i(mask), .data_o(rdata[3]), .valid_o(valid[3]), .stall_o(stall[3]), .err_o(err[3]));

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req   = '0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        mask  = '0;
    endtask

    // Issue one request to instance k (must be idle) and wait for its response
    task automatic access(input int k, input logic w, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic v, output logic e,
                          output logic [31:0] q, output int lat);
        req    = '0;
        req[k] = 1'b1;
        we     = w;
        addr   = a;
        wdata  = d;
        mask   = m;
        tick();
        req = '0;
        lat = 1;
        while (!(valid[k] | err[k]) && lat < 40) begin
            tick();
            lat++;
        end
        v = valid[k];
        e = err[k];
        q = rdata[k];
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 ^ 32'(i * 32'h0001_0101);
    endfunction

    task automatic test_reset();
        idle_inputs();
        #2 rst_b = 1'b0;
        #10;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({valid[k], err[k], stall[k]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got v/e/s=%b%b%b want 000", k, valid[k], err[k], stall[k]);
            end
            checks++;
            if (rdata[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h want 0", k, rdata[k]);
            end
        end
        @(negedge clk);
        rst_b = 1'b1;
        tick();
    endtask

    // Write then read word 5 back-to-back at zero wait states
    task automatic test_basic();
        req = 4'b0001; we = 1'b1; addr = 30'd5; wdata = 32'hDEADBEEF; mask = 4'hF;
        checks++;
        if (stall[0] !== 1'b0) begin errors++; $display("FAIL basic_stall_c0: got %b want 0", stall[0]); end
        tick();
        checks++;
        if ({valid[0], err[0], stall[0]} !== 3'b100) begin
            errors++; $display("FAIL basic_wr_c1: got v/e/s=%b%b%b want 100", valid[0], err[0], stall[0]);
        end
        we = 1'b0;
        tick();
        checks++;
        if ({valid[0], err[0], stall[0]} !== 3'b100) begin
            errors++; $display("FAIL basic_rd_c2: got v/e/s=%b%b%b want 100", valid[0], err[0], stall[0]);
        end
        checks++;
        if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h want deadbeef", rdata[0]); end
        req = '0;
        tick();
        checks++;
        if (valid[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_idle_hold: got v=%b d=%h want 0/deadbeef", valid[0], rdata[0]);
        end
    endtask

    // Single-byte update and a mask=0 no-op write
    task automatic test_byte_mask();
        logic v, e;
        logic [31:0] q;
        int lat;
        access(0, 1'b1, 30'd5, 32'h00AA0000, 4'b0100, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL mask_wr: got v=%b e=%b lat=%0d want 1/0/1", v, e, lat);
        end
        access(0, 1'b0, 30'd5, 32'h0, 4'h0, v, e, q, lat);
        checks++;
        if (q !== 32'hDEAABEEF || lat != 1) begin
            errors++; $display("FAIL mask_rd: got %h lat=%0d want deaabeef/1", q, lat);
        end
        access(0, 1'b1, 30'd5, 32'hFFFFFFFF, 4'h0, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL mask0_ack: got v=%b e=%b want 1/0", v, e); end
        access(0, 1'b0, 30'd5, 32'h0, 4'h0, v, e, q, lat);
        checks++;
        if (q !== 32'hDEAABEEF) begin errors++; $display("FAIL mask0_rd: got %h want deaabeef", q); end
    endtask

    // Three wait states with a second request held through the busy window
    task automatic test_wait_states();
        logic v, e;
        logic [31:0] q;
        int lat;
        access(1, 1'b1, 30'd7, 32'h12345678, 4'hF, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || lat != 4) begin errors++; $display("FAIL ws_pre7: got v=%b lat=%0d want 1/4", v, lat); end
        access(1, 1'b1, 30'd8, 32'hCAFEF00D, 4'hF, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || lat != 4) begin errors++; $display("FAIL ws_pre8: got v=%b lat=%0d want 1/4", v, lat); end
        req = 4'b0010; we = 1'b0; addr = 30'd7;
        checks++;
        if (stall[1] !== 1'b0) begin errors++; $display("FAIL ws_c0_stall: got %b want 0", stall[1]); end
        tick();
        addr = 30'd8;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (stall[1] !== 1'b1 || valid[1] !== 1'b0) begin
                errors++; $display("FAIL ws_busy_c%0d: got s=%b v=%b want 1/0", c, stall[1], valid[1]);
            end
            tick();
        end
        checks++;
        if ({valid[1], err[1], stall[1]} !== 3'b100 || rdata[1] !== 32'h12345678) begin
            errors++; $display("FAIL ws_c4: got v/e/s=%b%b%b d=%h want 100/12345678", valid[1], err[1], stall[1], rdata[1]);
        end
        tick();
        req = '0;
        for (int c = 5; c <= 7; c++) begin
            checks++;
            if (stall[1] !== 1'b1 || valid[1] !== 1'b0) begin
                errors++; $display("FAIL ws_busy2_c%0d: got s=%b v=%b want 1/0", c, stall[1], valid[1]);
            end
            tick();
        end
        checks++;
        if ({valid[1], stall[1]} !== 2'b10 || rdata[1] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL ws_c8: got v=%b s=%b d=%h want 1/0/cafef00d", valid[1], stall[1], rdata[1]);
        end
        tick();
        checks++;
        if (valid[1] !== 1'b0) begin errors++; $display("FAIL ws_c9_pulse: got v=%b want 0", valid[1]); end
    endtask

    // Out-of-range accesses around a base of 0x100 and a full-RAM scan
    task automatic test_out_of_range();
        req = 4'b1000; we = 1'b1; mask = 4'hF;
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr  = 30'h100 + 30'(i);
            wdata = pat(i);
            tick();
            checks++;
            if (valid[3] !== 1'b1) begin errors++; $display("FAIL oor_fill[%0d]: got v=%b want 1", i, valid[3]); end
        end
        we = 1'b0; addr = 30'h0FF;
        tick();
        checks++;
        if ({valid[3], err[3]} !== 2'b01 || rdata[3] !== 32'h0) begin
            errors++; $display("FAIL oor_rd_0ff: got v=%b e=%b d=%h want 0/1/0", valid[3], err[3], rdata[3]);
        end
        we = 1'b1; addr = 30'h500; wdata = 32'hFFFFFFFF;
        tick();
        checks++;
        if ({valid[3], err[3]} !== 2'b01) begin
            errors++; $display("FAIL oor_wr_500: got v=%b e=%b want 0/1", valid[3], err[3]);
        end
        we = 1'b0; addr = 30'h4FF;
        tick();
        checks++;
        if ({valid[3], err[3]} !== 2'b10 || rdata[3] !== pat(1023)) begin
            errors++; $display("FAIL oor_rd_4ff: got v=%b e=%b d=%h want 1/0/%h", valid[3], err[3], rdata[3], pat(1023));
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr = 30'h100 + 30'(i);
            tick();
            checks++;
            if (valid[3] !== 1'b1 || rdata[3] !== pat(i)) begin
                errors++; $display("FAIL oor_scan[%0d]: got v=%b d=%h want 1/%h", i, valid[3], rdata[3], pat(i));
            end
        end
        req = '0;
        tick();
    endtask

    // Reset during a 4-wait write must abort it without committing
    task automatic test_reset_mid();
        logic v, e;
        logic [31:0] q;
        int lat;
        access(2, 1'b1, 30'd3, 32'h11111111, 4'hF, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || lat != 5) begin errors++; $display("FAIL rm_pre: got v=%b lat=%0d want 1/5", v, lat); end
        req = 4'b0100; we = 1'b1; addr = 30'd3; wdata = 32'h22222222; mask = 4'hF;
        tick();
        checks++;
        if (stall[2] !== 1'b1) begin errors++; $display("FAIL rm_c1_stall: got %b want 1", stall[2]); end
        req = '0;
        tick();
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({valid[2], err[2], stall[2]} !== 3'b000 || rdata[2] !== 32'h0) begin
            errors++; $display("FAIL rm_async: got v/e/s=%b%b%b d=%h want 000/0", valid[2], err[2], stall[2], rdata[2]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (valid[2] !== 1'b0 || err[2] !== 1'b0 || stall[2] !== 1'b0) begin
                errors++; $display("FAIL rm_quiet[%0d]: got v/e/s=%b%b%b want 000", c, valid[2], err[2], stall[2]);
            end
        end
        access(2, 1'b0, 30'd3, 32'h0, 4'h0, v, e, q, lat);
        checks++;
        if (v !== 1'b1 || q !== 32'h11111111) begin
            errors++; $display("FAIL rm_readback: got v=%b d=%h want 1/11111111", v, q);
        end
    endtask

    // Pipelined random writes (some mask=0) then reads against a model
    task automatic test_back_to_back();
        logic [31:0] model [64];
        int          addrs [100];
        logic [3:0]  m;
        logic [31:0] d;
        req = 4'b0001; we = 1'b1; mask = 4'hF;
        for (int i = 0; i < 64; i++) begin
            addr     = 30'(64 + i);
            wdata    = $urandom;
            model[i] = wdata;
            tick();
            checks++;
            if (valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_fill[%0d]: got v=%b want 1", i, valid[0]); end
        end
        for (int n = 0; n < 100; n++) begin
            addrs[n] = int'($urandom_range(63));
            m = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (m[b]) model[addrs[n]][8*b +: 8] = d[8*b +: 8];
            end
            addr = 30'(64 + addrs[n]); wdata = d; mask = m;
            tick();
            checks++;
            if (valid[0] !== 1'b1 || err[0] !== 1'b0) begin
                errors++; $display("FAIL b2b_wr[%0d]: got v=%b e=%b want 1/0", n, valid[0], err[0]);
            end
        end
        we = 1'b0;
        for (int n = 0; n < 100; n++) begin
            addr = 30'(64 + addrs[n]);
            tick();
            checks++;
            if (valid[0] !== 1'b1 || rdata[0] !== model[addrs[n]]) begin
                errors++; $display("FAIL b2b_rd[%0d]: got v=%b d=%h want 1/%h", n, valid[0], rdata[0], model[addrs[n]]);
            end
        end
        req = '0;
        tick();
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_tail: got v=%b want 0", valid[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_mask();
        test_wait_states();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
